// File: rtl/spi_pkg.sv
// spi_pkg: shared state type and constants for the mode-3 SPI responder.
package spi_pkg;
    typedef enum logic [1:0] {RESYNC, IDLE, ARMED, ACTIVE} spi_slv_state_t;
    localparam int SPI_WIDTH = 16;
    localparam logic SPI_CPOL = 1'b1;
    localparam logic SPI_CPHA = 1'b1;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser with rise/fall pulses from the last two flops.
module spi_sync_edge #(
    parameter int STAGES = 2,
    parameter logic INIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES:0] s;
    always_ff @(posedge clk)
        if (rst) s <= {(STAGES+1){INIT}};
        else s <= {s[STAGES-1:0], d};
    assign q = s[STAGES-1];
    assign rise = s[STAGES-1] & ~s[STAGES];
    assign fall = ~s[STAGES-1] & s[STAGES];
endmodule

// File: rtl/spi_slv16.sv
// spi_slv16: mode-3 SPI responder returning a preloaded word while capturing the command word.
module spi_slv16
    import spi_pkg::*;
#(
    parameter int WIDTH = SPI_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SS_n,
    input  logic             SCLK,
    input  logic             MOSI,
    output logic             MISO,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             wrt,
    output logic             busy,
    output logic [WIDTH-1:0] rx_data,
    output logic             rdy,
    input  logic             clr_rdy,
    output logic             frm_err
);
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH + 1);
    spi_slv_state_t state;
    logic ss_s, ss_rise, ss_fall, sclk_rise, sclk_fall, mosi_s;
    logic unused_sclk_q, unused_mosi_rise, unused_mosi_fall;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] shft, shft_fin;
    logic smpl, smpl_nxt;
    // SS reset value of 0 keeps RESYNC waiting for a genuine high, so a frame in progress is skipped
    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_ss (
        .clk(clk), .rst(rst), .d(SS_n), .q(ss_s), .rise(ss_rise), .fall(ss_fall));
    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(SPI_CPOL)) u_sclk (
        .clk(clk), .rst(rst), .d(SCLK), .q(unused_sclk_q), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_mosi (
        .clk(clk), .rst(rst), .d(MOSI), .q(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall));
    assign smpl_nxt = sclk_rise ? mosi_s : smpl;
    assign cnt_nxt = (sclk_rise && cnt != CNT_MAX) ? cnt + 1'b1 : cnt;
    assign shft_fin = {shft[WIDTH-2:0], smpl_nxt};
    assign MISO = (busy && !ss_s) ? shft[WIDTH-1] : 1'bz;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RESYNC;
            busy <= 1'b0;
            rdy <= 1'b0;
            frm_err <= 1'b0;
            rx_data <= '0;
            shft <= '0;
            smpl <= 1'b0;
            cnt <= '0;
        end else begin
            frm_err <= 1'b0;
            if (clr_rdy) rdy <= 1'b0;
            if (!busy && wrt) begin
                shft <= tx_data;
                rdy <= 1'b0;
            end
            case (state)
                RESYNC: if (ss_s) state <= IDLE;
                IDLE: if (ss_fall) begin
                    state <= ARMED;
                    cnt <= '0;
                    busy <= 1'b1;
                end
                ARMED: if (ss_rise) begin
                    frm_err <= 1'b1;
                    busy <= 1'b0;
                    state <= IDLE;
                end else if (sclk_rise) begin
                    smpl <= mosi_s;
                    cnt <= cnt_nxt;
                    state <= ACTIVE;
                end
                ACTIVE: if (ss_rise) begin
                    shft <= shft_fin;
                    smpl <= smpl_nxt;
                    cnt <= cnt_nxt;
                    busy <= 1'b0;
                    state <= IDLE;
                    if (cnt_nxt == CNT_FULL) begin
                        rx_data <= shft_fin;
                        rdy <= 1'b1;
                    end else frm_err <= 1'b1;
                end else begin
                    if (sclk_rise) begin
                        smpl <= mosi_s;
                        cnt <= cnt_nxt;
                    end
                    if (sclk_fall) shft <= {shft[WIDTH-2:0], smpl};
                end
                default: state <= RESYNC;
            endcase
        end
    end
endmodule
